// File: rtl/stage2_cnn_kernel_mc_if.sv
// ---------------------------------------------------------------------------
// stage2_cnn_kernel_mc_if
// Bundles the control, data and result signals of the multi-channel CNN
// kernel. The producer side uses the master modport and the kernel uses the
// slave modport.
//
//   i_clear      : abort of partial accumulation and in-flight beats
//   i_relu       : apply ReLU to the result (taken with the last-channel beat)
//   i_in_valid   : one channel beat present
//   i_in_fmap    : KX*KY signed IBW-bit window elements, k = y*KX + x
//   i_cnn_weight : KX*KY signed W_BW-bit weights, same packing
//   i_bias       : signed bias (taken with the last-channel beat)
//   o_ot_valid   : one-cycle result strobe
//   o_ot_acc     : signed, saturated, optionally ReLU'd result
//   o_ch_idx     : channel index expected for the next accepted beat
//   o_sat        : sticky saturation flag
// ---------------------------------------------------------------------------
interface stage2_cnn_kernel_mc_if #(
  parameter int KX   = 5,
  parameter int KY   = 5,
  parameter int IBW  = 20,
  parameter int W_BW = 8,
  parameter int CH   = 3,
  parameter int B_BW = 16,
  parameter int OBW  = 24
) ();

  logic                   i_clear;
  logic                   i_relu;
  logic                   i_in_valid;
  logic [KX*KY*IBW-1:0]   i_in_fmap;
  logic [KX*KY*W_BW-1:0]  i_cnn_weight;
  logic [B_BW-1:0]        i_bias;
  logic                   o_ot_valid;
  logic [OBW-1:0]         o_ot_acc;
  logic [$clog2(CH):0]    o_ch_idx;
  logic                   o_sat;

  modport master (
    output i_clear, i_relu, i_in_valid, i_in_fmap, i_cnn_weight, i_bias,
    input  o_ot_valid, o_ot_acc, o_ch_idx, o_sat
  );

  modport slave (
    input  i_clear, i_relu, i_in_valid, i_in_fmap, i_cnn_weight, i_bias,
    output o_ot_valid, o_ot_acc, o_ch_idx, o_sat
  );

endinterface

// File: rtl/stage2_cnn_kernel_mc.sv
// ---------------------------------------------------------------------------
// stage2_cnn_kernel_mc
// Multi-channel KX x KY convolution kernel. Each beat carries one channel's
// window and weights. A three-stage pipeline multiplies (stage 1), reduces
// the products to one sum (stage 2) and accumulates across CH channels
// (stage 3). On the last channel the bias is added, ReLU is optionally
// applied and the result is clamped to OBW bits and presented for one cycle.
//
//   clk     : single clock, rising edge
//   reset_n : synchronous active-low reset (priority over i_clear)
//   bus     : slave side of stage2_cnn_kernel_mc_if (see interface header)
// ---------------------------------------------------------------------------
module stage2_cnn_kernel_mc #(
  parameter int KX   = 5,
  parameter int KY   = 5,
  parameter int IBW  = 20,
  parameter int W_BW = 8,
  parameter int CH   = 3,
  parameter int B_BW = 16,
  parameter int OBW  = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  stage2_cnn_kernel_mc_if.slave bus
);

  localparam int NK     = KX * KY;
  localparam int M_BW   = IBW + W_BW;
  localparam int ACC_BW = M_BW + $clog2(KX * KY * CH) + 2;
  localparam int CW     = $clog2(CH) + 1;
  // One spare bit above the wider of accumulator and output keeps the
  // clamp comparisons free of overflow.
  localparam int EXT_BW = ((ACC_BW > OBW) ? ACC_BW : OBW) + 1;

  localparam logic signed [EXT_BW-1:0] OUT_MAX =
    {{(EXT_BW - OBW + 1){1'b0}}, {(OBW - 1){1'b1}}};
  localparam logic signed [EXT_BW-1:0] OUT_MIN =
    {{(EXT_BW - OBW + 1){1'b1}}, {(OBW - 1){1'b0}}};
  localparam logic [CW-1:0] LAST_CH = CW'(CH - 1);

  // Full-precision signed product of one window element and its weight.
  function automatic logic signed [M_BW-1:0] mul_elem(
    input logic signed [IBW-1:0]  a,
    input logic signed [W_BW-1:0] b
  );
    logic signed [M_BW-1:0] ax;
    logic signed [M_BW-1:0] bx;
    ax = {{W_BW{a[IBW-1]}}, a};
    bx = {{IBW{b[W_BW-1]}}, b};
    return ax * bx;
  endfunction

  // Channel counter
  logic [CW-1:0]              ch_q, ch_d;

  // Stage 1: products plus side-band captured with the beat
  logic                       s1_valid_q, s1_valid_d;
  logic                       s1_last_q, s1_last_d;
  logic                       s1_relu_q, s1_relu_d;
  logic [B_BW-1:0]            s1_bias_q, s1_bias_d;
  logic signed [M_BW-1:0]     prod_q [NK];
  logic signed [M_BW-1:0]     prod_d [NK];

  // Stage 2: reduced window sum
  logic                       s2_valid_q, s2_valid_d;
  logic                       s2_last_q, s2_last_d;
  logic                       s2_relu_q, s2_relu_d;
  logic [B_BW-1:0]            s2_bias_q, s2_bias_d;
  logic signed [ACC_BW-1:0]   sum_q, sum_d;

  // Stage 3: channel accumulator and output registers
  logic signed [ACC_BW-1:0]   acc_q, acc_d;
  logic                       ot_valid_q, ot_valid_d;
  logic [OBW-1:0]             ot_acc_q, ot_acc_d;
  logic                       sat_q, sat_d;

  // Combinational helpers
  logic                       accept;
  logic                       ch_last;
  logic signed [ACC_BW-1:0]   bias_ext;
  logic signed [ACC_BW-1:0]   result;
  logic signed [EXT_BW-1:0]   post;
  logic signed [EXT_BW-1:0]   clamped;

  always_comb begin
    accept     = bus.i_in_valid & ~bus.i_clear;
    ch_last    = (ch_q == LAST_CH);

    ch_d       = ch_q;
    s1_valid_d = accept;
    s1_last_d  = s1_last_q;
    s1_relu_d  = s1_relu_q;
    s1_bias_d  = s1_bias_q;
    prod_d     = prod_q;
    s2_valid_d = s1_valid_q;
    s2_last_d  = s2_last_q;
    s2_relu_d  = s2_relu_q;
    s2_bias_d  = s2_bias_q;
    sum_d      = sum_q;
    acc_d      = acc_q;
    ot_valid_d = 1'b0;
    ot_acc_d   = ot_acc_q;
    sat_d      = sat_q;
    bias_ext   = '0;
    result     = '0;
    post       = '0;
    clamped    = '0;

    // Stage 1: data registers only move on an accepted beat so idle gaps
    // leave the pipeline contents untouched.
    if (accept) begin
      for (int k = 0; k < NK; k++) begin
        prod_d[k] = mul_elem(bus.i_in_fmap[k*IBW +: IBW],
                             bus.i_cnn_weight[k*W_BW +: W_BW]);
      end
      s1_bias_d = bus.i_bias;
      s1_relu_d = bus.i_relu;
      s1_last_d = ch_last;
      ch_d      = ch_last ? '0 : ch_q + CW'(1);
    end

    // Stage 2: adder tree flattened into a sign-extended running sum.
    if (s1_valid_q) begin
      sum_d = '0;
      for (int k = 0; k < NK; k++) begin
        sum_d = sum_d + {{(ACC_BW - M_BW){prod_q[k][M_BW-1]}}, prod_q[k]};
      end
      s2_last_d = s1_last_q;
      s2_relu_d = s1_relu_q;
      s2_bias_d = s1_bias_q;
    end

    // Stage 3: the last channel folds in the bias and restarts the
    // accumulator in the same cycle so back-to-back outputs need no bubble.
    if (s2_valid_q) begin
      if (s2_last_q) begin
        bias_ext = {{(ACC_BW - B_BW){s2_bias_q[B_BW-1]}}, s2_bias_q};
        result   = acc_q + sum_q + bias_ext;
        acc_d    = '0;
        post     = {{(EXT_BW - ACC_BW){result[ACC_BW-1]}}, result};
        if (s2_relu_q && post[EXT_BW-1]) begin
          post = '0;
        end
        if (post > OUT_MAX) begin
          clamped = OUT_MAX;
        end else if (post < OUT_MIN) begin
          clamped = OUT_MIN;
        end else begin
          clamped = post;
        end
        ot_acc_d   = clamped[OBW-1:0];
        ot_valid_d = 1'b1;
        if (clamped != post) begin
          sat_d = 1'b1;
        end
      end else begin
        acc_d = acc_q + sum_q;
      end
    end

    // Abort: drop every in-flight beat and partial sum; the last published
    // result stays on o_ot_acc.
    if (bus.i_clear) begin
      ch_d       = '0;
      acc_d      = '0;
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      ot_valid_d = 1'b0;
      ot_acc_d   = ot_acc_q;
      sat_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ch_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_relu_q  <= 1'b0;
      s1_bias_q  <= '0;
      prod_q     <= '{default: '0};
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_relu_q  <= 1'b0;
      s2_bias_q  <= '0;
      sum_q      <= '0;
      acc_q      <= '0;
      ot_valid_q <= 1'b0;
      ot_acc_q   <= '0;
      sat_q      <= 1'b0;
    end else begin
      ch_q       <= ch_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_relu_q  <= s1_relu_d;
      s1_bias_q  <= s1_bias_d;
      prod_q     <= prod_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s2_relu_q  <= s2_relu_d;
      s2_bias_q  <= s2_bias_d;
      sum_q      <= sum_d;
      acc_q      <= acc_d;
      ot_valid_q <= ot_valid_d;
      ot_acc_q   <= ot_acc_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.o_ot_valid = ot_valid_q;
  assign bus.o_ot_acc   = ot_acc_q;
  assign bus.o_ch_idx   = ch_q;
  assign bus.o_sat      = sat_q;

endmodule
